// File: rtl/pacote_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pacote_mem : shared types and helpers for the data-memory arbiter     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pacote_mem;

    localparam int DATA_W_PAD = 32;
    localparam int ADDR_W_PAD = 32;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    // Word access is legal only on a 4-byte boundary.
    function automatic logic alinhado(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_memoria_dados_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_memoria_dados_if : requester and memory-side bus of arbiter   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface arbitro_memoria_dados_if
    import pacote_mem::*;
#(
    parameter int DATA_W = DATA_W_PAD,
    parameter int ADDR_W = ADDR_W_PAD
);
    logic              req0,   req1;
    logic              we0,    we1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              done0,  done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err0,   err1;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] mem_dado_in;
    logic [DATA_W-1:0] mem_dado_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dado_out,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
               mem_write, mem_read, mem_endereco, mem_dado_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dado_out,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
               mem_write, mem_read, mem_endereco, mem_dado_in
    );

endinterface
`default_nettype wire

// File: rtl/arbitro_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_rr2 : combinational two-way round-robin / fixed-priority pick |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module arbitro_rr2 #(
    parameter bit PRIO_FIXA = 1'b0
) (
    input  wire logic req0,
    input  wire logic req1,
    input  wire logic ultimo,
    output logic      vencedor,
    output logic      valido
);

    always_comb begin
        valido   = req0 | req1;
        vencedor = req1;
        if (req0 && req1) begin
            // On a tie the port not granted last wins, unless port 0 is fixed master.
            vencedor = PRIO_FIXA ? 1'b0 : ~ultimo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbitro_memoria_dados.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_memoria_dados : shares one data memory between two requesters |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module arbitro_memoria_dados
    import pacote_mem::*;
#(
    parameter int DATA_W    = DATA_W_PAD,
    parameter int ADDR_W    = ADDR_W_PAD,
    parameter bit PRIO_FIXA = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    arbitro_memoria_dados_if.slave bus
);

    estado_t           r_estado;
    logic              r_dono;
    logic              r_ultimo;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_vencedor;
    logic              w_valido;
    logic              w_alinhado;
    logic              w_acesso;
    logic              w_resposta;
    logic [DATA_W-1:0] w_rdado;

    arbitro_rr2 #(
        .PRIO_FIXA (PRIO_FIXA)
    ) u_arbitro_rr2 (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .ultimo   (r_ultimo),
        .vencedor (w_vencedor),
        .valido   (w_valido)
    );

    assign w_alinhado = alinhado(r_addr[1:0]);
    assign w_acesso   = (r_estado == ACESSO);
    assign w_resposta = (r_estado == RESPOSTA);
    assign w_rdado    = w_alinhado ? bus.mem_dado_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
            r_dono   <= 1'b0;
            r_ultimo <= 1'b1;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_estado)
                // RESPOSTA re-arbitrates so back-to-back accesses need no idle cycle.
                OCIOSO, RESPOSTA: begin
                    if (w_valido) begin
                        r_estado <= ACESSO;
                        r_dono   <= w_vencedor;
                        r_ultimo <= w_vencedor;
                        r_we     <= w_vencedor ? bus.we1    : bus.we0;
                        r_addr   <= w_vencedor ? bus.addr1  : bus.addr0;
                        r_wdata  <= w_vencedor ? bus.wdata1 : bus.wdata0;
                    end else begin
                        r_estado <= OCIOSO;
                    end
                end
                ACESSO: begin
                    r_estado <= RESPOSTA;
                    r_err    <= ~w_alinhado;
                    if (!r_we) begin
                        if (r_dono) r_rdata1 <= w_rdado;
                        else        r_rdata0 <= w_rdado;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bus.gnt0   = w_acesso   & ~r_dono;
    assign bus.gnt1   = w_acesso   &  r_dono;
    assign bus.done0  = w_resposta & ~r_dono;
    assign bus.done1  = w_resposta &  r_dono;
    assign bus.err0   = w_resposta & ~r_dono & r_err;
    assign bus.err1   = w_resposta &  r_dono & r_err;
    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;

    // Memory strobes derive from state only, so an async reset drops them at once.
    assign bus.mem_write    = w_acesso &  r_we & w_alinhado;
    assign bus.mem_read     = w_acesso & ~r_we & w_alinhado;
    assign bus.mem_endereco = w_acesso ? r_addr  : '0;
    assign bus.mem_dado_in  = w_acesso ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria_dados.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arbitro_memoria_dados : directed bench, round-robin and fixed prio |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_arbitro_memoria_dados;

    logic clk;
    logic rst_n;
    logic rst_nb;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   wr_antes;

    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_dado;
    logic [31:0] mem_a [0:63];

    arbitro_memoria_dados_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    arbitro_memoria_dados_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

    arbitro_memoria_dados #(.DATA_W(32), .ADDR_W(32), .PRIO_FIXA(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    arbitro_memoria_dados #(.DATA_W(32), .ADDR_W(32), .PRIO_FIXA(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_a.mem_dado_out = mem_a[bus_a.mem_endereco[7:2]];
    assign bus_b.mem_dado_out = 32'h5A5A_0000 | bus_b.mem_endereco;

    always @(posedge clk) begin
        if (bd_we)
            mem_a[bd_idx] <= bd_dado;
        else if (bus_a.mem_write)
            mem_a[bus_a.mem_endereco[7:2]] <= bus_a.mem_dado_in;
        if (bus_a.mem_write)
            wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_cnt = 0;
        rst_n  = 1'b0;
        rst_nb = 1'b0;
        bd_we  = 1'b0;
        bd_idx = '0;
        bd_dado = '0;
        bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
        bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
        bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
        bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;

        // Backdoor preload while both instances sit in reset.
        bd_we = 1'b1;
        bd_idx = 6'h10; bd_dado = 32'hDEAD_BEEF; tick();
        bd_idx = 6'h04; bd_dado = 32'h1111_1111; tick();
        bd_idx = 6'h20; bd_dado = 32'h0000_0000; tick();
        bd_idx = 6'h08; bd_dado = 32'h0000_0000; tick();
        bd_we = 1'b0;

        chk("rst_ctrl_a", 32'({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1,
                               bus_a.err0, bus_a.err1, bus_a.mem_write, bus_a.mem_read}), 32'h0);
        chk("rst_rdata0", bus_a.rdata0, 32'h0);
        chk("rst_rdata1", bus_a.rdata1, 32'h0);
        chk("rst_mem_addr", bus_a.mem_endereco, 32'h0);
        chk("rst_mem_din", bus_a.mem_dado_in, 32'h0);
        chk("rst_ctrl_b", 32'({bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1}), 32'h0);

        rst_n = 1'b1;
        rst_nb = 1'b1;
        tick();
        chk("idle_after_rst", 32'({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1}), 32'h0);

        // Load after reset: gnt one cycle, done the next.
        bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 32'h40;
        tick();
        chk("ld_gnt", 32'({bus_a.gnt0, bus_a.gnt1}), 32'h2);
        chk("ld_mem_rd", 32'({bus_a.mem_read, bus_a.mem_write}), 32'h2);
        chk("ld_mem_addr", bus_a.mem_endereco, 32'h40);
        bus_a.req0 = 0;
        tick();
        chk("ld_done", 32'({bus_a.done0, bus_a.done1, bus_a.err0}), 32'h4);
        chk("ld_rdata", bus_a.rdata0, 32'hDEAD_BEEF);
        chk("ld_mem_off", 32'({bus_a.mem_read, bus_a.mem_write}), 32'h0);
        tick();
        chk("ld_hold", bus_a.rdata0, 32'hDEAD_BEEF);

        // Round-robin tie; port 0 was granted last so port 1 goes first.
        bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 32'h40;
        bus_a.req1 = 1; bus_a.we1 = 1; bus_a.addr1 = 32'h80; bus_a.wdata1 = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", 32'({bus_a.gnt0, bus_a.gnt1}), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k == 0) chk("rr_mem_wr", 32'({bus_a.mem_write, bus_a.mem_read}), 32'h2);
            if (k == 2) bus_a.req1 = 0;
            if (k == 3) bus_a.req0 = 0;
            tick();
            chk("rr_done", 32'({bus_a.done0, bus_a.done1}), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k % 2 == 1) chk("rr_rdata0", bus_a.rdata0, 32'hDEAD_BEEF);
        end
        tick();
        chk("rr_idle", 32'({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1}), 32'h0);
        chk("rr_mem80", mem_a[6'h20], 32'h1234_5678);

        bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 32'h80;
        tick();
        chk("ld80_gnt", 32'({bus_a.gnt0, bus_a.gnt1}), 32'h2);
        bus_a.req0 = 0;
        tick();
        chk("ld80_rdata", bus_a.rdata0, 32'h1234_5678);

        // Misaligned store issued during RESPOSTA goes straight to ACESSO.
        bus_a.req1 = 1; bus_a.we1 = 1; bus_a.addr1 = 32'h42; bus_a.wdata1 = 32'hFFFF_FFFF;
        wr_antes = wr_cnt;
        tick();
        chk("mis_st_gnt", 32'({bus_a.gnt0, bus_a.gnt1}), 32'h1);
        chk("mis_st_en", 32'({bus_a.mem_write, bus_a.mem_read}), 32'h0);
        bus_a.req1 = 0;
        tick();
        chk("mis_st_done", 32'({bus_a.done1, bus_a.err1, bus_a.err0}), 32'h6);
        chk("mis_st_rdata1", bus_a.rdata1, 32'h0);
        tick();
        chk("mis_st_mem40", mem_a[6'h10], 32'hDEAD_BEEF);
        chk("mis_st_nowr", 32'(wr_cnt), 32'(wr_antes));

        // Misaligned load returns zero with err.
        bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 32'h41;
        tick();
        chk("mis_ld_en", 32'({bus_a.gnt0, bus_a.mem_read}), 32'h2);
        bus_a.req0 = 0;
        tick();
        chk("mis_ld_done", 32'({bus_a.done0, bus_a.err0}), 32'h3);
        chk("mis_ld_rdata", bus_a.rdata0, 32'h0);
        tick();

        // Store then immediate load of the same word.
        bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 32'h20; bus_a.wdata0 = 32'h5;
        tick();
        chk("sl_st_gnt", 32'({bus_a.gnt0, bus_a.mem_write}), 32'h3);
        bus_a.we0 = 0;
        tick();
        chk("sl_st_done", 32'({bus_a.done0, bus_a.err0}), 32'h2);
        tick();
        chk("sl_ld_gnt", 32'({bus_a.gnt0, bus_a.mem_read}), 32'h3);
        bus_a.req0 = 0;
        tick();
        chk("sl_ld_rdata", bus_a.rdata0, 32'h5);
        tick();

        // Fixed priority: port 1 only after req0 drops.
        bus_b.req0 = 1; bus_b.we0 = 0; bus_b.addr0 = 32'h4;
        bus_b.req1 = 1; bus_b.we1 = 0; bus_b.addr1 = 32'h8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fp_gnt0", 32'({bus_b.gnt0, bus_b.gnt1}), 32'h2);
            if (k == 2) bus_b.req0 = 0;
            tick();
            chk("fp_done0", 32'({bus_b.done0, bus_b.done1}), 32'h2);
        end
        tick();
        chk("fp_gnt1", 32'({bus_b.gnt0, bus_b.gnt1}), 32'h1);
        bus_b.req1 = 0;
        tick();
        chk("fp_done1", 32'({bus_b.done0, bus_b.done1}), 32'h1);
        chk("fp_rdata1", bus_b.rdata1, 32'h5A5A_0008);
        tick();

        // Reset asserted while a store is in ACESSO.
        bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 32'h10; bus_a.wdata0 = 32'hCAFE_F00D;
        tick();
        chk("rs_st_wr", 32'({bus_a.gnt0, bus_a.mem_write}), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("rs_ctrl", 32'({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1,
                            bus_a.err0, bus_a.err1, bus_a.mem_write, bus_a.mem_read}), 32'h0);
        chk("rs_mem_addr", bus_a.mem_endereco, 32'h0);
        chk("rs_mem_din", bus_a.mem_dado_in, 32'h0);
        chk("rs_rdata0", bus_a.rdata0, 32'h0);
        bus_a.req0 = 0;
        tick();
        chk("rs_mem10", mem_a[6'h04], 32'h1111_1111);
        chk("rs_nodone", 32'(bus_a.done0), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rs_after", 32'({bus_a.gnt0, bus_a.done0, bus_a.mem_write}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
